// File: rtl/divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock, start/busy/done
// handshake, registered quotient/remainder and a divide-by-zero flag.
module divider #(
  parameter int n = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [n-1:0] in1,
  input  logic [n-1:0] in2,
  output logic         busy,
  output logic         done,
  output logic [n-1:0] quotient,
  output logic [n-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CW = $clog2(n + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [n-1:0]  r_div, r_q, w_qn;
  logic [n:0]    r_r, w_rsh, w_rn;
  logic          w_accept, w_last, w_zero;

  assign w_accept = start && (r_state == IDLE || r_state == DONE);
  assign w_zero   = (in2 == '0);
  assign w_last   = (r_cnt == CW'(1));
  assign busy     = (r_state == RUN);
  assign done     = (r_state == DONE);

  // Partial remainder is one bit wider than the divisor so the compare/subtract never overflows.
  assign w_rsh = {r_r[n-1:0], r_q[n-1]};

  always_comb begin
    w_rn = w_rsh;
    w_qn = {r_q[n-2:0], 1'b0};
    if (w_rsh >= {1'b0, r_div}) begin
      w_rn    = w_rsh - {1'b0, r_div};
      w_qn[0] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, DONE: begin
        if (w_accept)            w_next = w_zero ? DONE : RUN;
        else if (r_state == DONE) w_next = IDLE;
      end
      RUN:     if (w_last) w_next = DONE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt       <= '0;
      r_div       <= '0;
      r_q         <= '0;
      r_r         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (w_accept) begin
      if (w_zero) begin
        quotient    <= '1;
        remainder   <= in1;
        div_by_zero <= 1'b1;
      end else begin
        r_div <= in2;
        r_q   <= in1;
        r_r   <= '0;
        r_cnt <= CW'(n);
      end
    end else if (r_state == RUN) begin
      r_r   <= w_rn;
      r_q   <= w_qn;
      r_cnt <= r_cnt - CW'(1);
      // Outputs only change here, so working values never leak out mid-run.
      if (w_last) begin
        quotient    <= w_qn;
        remainder   <= w_rn[n-1:0];
        div_by_zero <= 1'b0;
      end
    end
  end

endmodule

// File: doc/divider.md
# divider

Sequential unsigned n-bit integer divider for the 8-bit calculator, the inverse operation to the multiplier datapath. It computes quotient and remainder by restoring shift-subtract, one quotient bit per clock. A start/busy/done handshake lets the calculator control logic launch an operation and pick up a registered result. A divide-by-zero flag replaces the out-of-range reporting done for products.

## Interface
- n, default 8, operand and result width in bits
- clk  input  1  system clock; all state changes on its rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  request a division; sampled on the rising edge of clk
- in1  input  n  dividend, unsigned; sampled only when start is accepted
- in2  input  n  divisor, unsigned; sampled only when start is accepted
- busy  output  1  high while a division is iterating (RUN state)
- done  output  1  one-cycle pulse: quotient/remainder/div_by_zero valid
- quotient  output  n  registered quotient, held until the next accepted start completes
- remainder  output  n  registered remainder, same hold rule
- div_by_zero  output  1  registered; set with done when in2 was 0

## Operation
- States: IDLE, RUN, DONE. Reset state IDLE.
- Reset values: busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, internal counter and working registers 0.
- Start is accepted on an edge where start=1 and the state is IDLE or DONE. In RUN, start is ignored (no queueing).
- On acceptance with in2!=0: latch divisor=in2, working quotient=in1, partial remainder=0 (n+1 bits), counter=n. Go to RUN.
- On acceptance with in2==0: go directly to DONE. quotient=all ones (255 for n=8), remainder=in1, div_by_zero=1.
- RUN step, once per edge: form shifted partial remainder R' = {R[n-1:0], Q[n-1]} and shift Q left.
  - If R' >= divisor: R = R' - divisor, Q LSB=1. Otherwise R = R', Q LSB=0.
  - Decrement counter. The step that takes the counter from 1 to 0 also transfers Q to quotient and R[n-1:0] to remainder, clears div_by_zero, and enters DONE.
- Output registers quotient/remainder/div_by_zero change only on entry to DONE. Intermediate working values are never visible on outputs.
- DONE lasts one cycle. With no accepted start it returns to IDLE; outputs hold.
- Widths: partial remainder is n+1 bits, so the subtraction never overflows. The result always satisfies in1 = quotient*in2 + remainder with remainder < in2 for in2!=0.
- rst asserted at any time, including mid-RUN: immediate return to IDLE with all outputs at reset values. No done pulse for the aborted operation.

## Timing
- Let edge E0 accept start with a nonzero divisor.
  - busy=1 from E0 through E_n (n cycles).
  - done=1 and results valid in the cycle after edge E_n. Latency is n edges; for n=8, done is seen 8 cycles after the start edge.
- Divide by zero: done=1 and div_by_zero=1 in the cycle immediately after E0. busy never rises.
- done is high for exactly one cycle per accepted start.
- Back-to-back: a start sampled during the DONE cycle is accepted at the DONE→next edge. busy rises (or, for a zero divisor, done re-pulses) with no idle gap. Outputs keep the previous result until the new result is written.
- start held high continuously: a new operation is accepted at every DONE cycle. Throughput is one result per n+1 cycles.
- in1/in2 may change freely after the accepting edge without affecting the result.

## Test plan
- Reset then start with in1=200, in2=7 → busy for 8 cycles, then done pulse with quotient=28, remainder=4, div_by_zero=0.
- in1=255, in2=1 → quotient=255, remainder=0. Then in1=5, in2=9 → quotient=0, remainder=5. Previous result holds on outputs until the second done.
- in1=123, in2=0 → done in the cycle after the start edge with quotient=255, remainder=123, div_by_zero=1, busy=0. A following 100/10 → quotient=10, remainder=0, div_by_zero cleared.
- Start 17/3, pulse start again with 250/250 at cycle 3 of RUN → the second request is ignored; one done with quotient=5, remainder=2.
- Hold start=1 with in1=9, in2=3 across two operations → two done pulses 9 cycles apart, each with quotient=3, remainder=0.
- Start 200/7, assert rst asynchronously at cycle 4 of RUN → outputs 0 immediately, state IDLE, no done. After release, 200/7 completes correctly.
